// File: rtl/dcache_pkg.sv
// Shared encodings, controller states and width helpers for the write-back data cache.
package dcache_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    function automatic int calc_off_w(input int words);
        return 2 + $clog2(words);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Word-select width; a one-word line still needs a 1-bit select signal.
    function automatic int calc_widx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/dcache_align.sv
// Byte-lane steering for the cache: load extraction/extension, store merge and alignment check.
module dcache_align
    import dcache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int OFF_W = calc_off_w(WORDS_PER_BLOCK),
    parameter int BLK_W = 32 * WORDS_PER_BLOCK
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [BLK_W-1:0] line,
    input  logic [31:0]      writedata,
    output logic [31:0]      load_data,
    output logic [BLK_W-1:0] store_line,
    output logic             misaligned
);

    localparam int WIDX_W = calc_widx_w(WORDS_PER_BLOCK);

    logic [WIDX_W-1:0] word_idx;
    logic [31:0]       words [WORDS_PER_BLOCK];
    logic [31:0]       sel_word;
    logic [31:0]       store_word;
    logic [31:0]       lane_data;
    logic [3:0]        byte_en;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    generate
        if (WORDS_PER_BLOCK == 1) begin : g_one_word
            assign word_idx = '0;
        end else begin : g_multi_word
            assign word_idx = offset[OFF_W-1:2];
        end

        // Only the addressed word is replaced; the rest of the line passes through.
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_words
            assign words[gi] = line[gi*32 +: 32];
            assign store_line[gi*32 +: 32] = (word_idx == WIDX_W'(gi)) ? store_word : words[gi];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
            assign store_word[gi*8 +: 8] = byte_en[gi] ? lane_data[gi*8 +: 8] : sel_word[gi*8 +: 8];
        end
    endgenerate

    assign sel_word = words[word_idx];

    always_comb begin
        sel_byte = sel_word[7:0];
        case (offset[1:0])
            2'd1:    sel_byte = sel_word[15:8];
            2'd2:    sel_byte = sel_word[23:16];
            2'd3:    sel_byte = sel_word[31:24];
            default: sel_byte = sel_word[7:0];
        endcase
        sel_half = offset[1] ? sel_word[31:16] : sel_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = sel_word;
        endcase
    end

    // Narrow stores replicate their data across lanes; byte_en picks the live ones.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = writedata;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << offset[1:0];
                lane_data = {4{writedata[7:0]}};
            end
            F3_H, F3_HU: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{writedata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = writedata;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = offset[0];
            F3_W:        misaligned = |offset[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dcache_wb_param.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage and block memory.
module dcache_wb_param
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS = 8,
    parameter int WORDS_PER_BLOCK = 4,
    localparam int OFF_W = calc_off_w(WORDS_PER_BLOCK),
    localparam int IDX_W = calc_idx_w(SETS),
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W,
    localparam int BLK_W = 32 * WORDS_PER_BLOCK
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_W-1:0]       address,
    input  logic [2:0]              funct3,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    busywait,
    output logic                    misaligned,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-OFF_W-1:0] mem_address,
    output logic [BLK_W-1:0]        mem_writedata,
    input  logic [BLK_W-1:0]        mem_readdata,
    input  logic                    mem_busywait
);

    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    state_t state_reg;
    state_t state_next;

    logic [SETS-1:0]  valid_reg;
    logic [SETS-1:0]  dirty_reg;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [BLK_W-1:0] data_mem [SETS];

    logic [BLK_W-1:0] line;
    logic [TAG_W-1:0] line_tag;
    logic [BLK_W-1:0] store_line;
    logic [31:0]      load_data;
    logic             align_fault;
    logic             req;
    logic             access_ok;
    logic             hit;
    logic             wr_hit;
    logic             fetch_done;

    assign offset   = address[OFF_W-1:0];
    assign index    = address[OFF_W +: IDX_W];
    assign tag      = address[ADDR_W-1 -: TAG_W];

    assign line     = data_mem[index];
    assign line_tag = tag_mem[index];
    assign hit      = valid_reg[index] && (line_tag == tag);

    assign req       = read | write;
    assign access_ok = req && !align_fault;

    dcache_align #(
        .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
    ) u_align (
        .funct3    (funct3),
        .offset    (offset),
        .line      (line),
        .writedata (writedata),
        .load_data (load_data),
        .store_line(store_line),
        .misaligned(align_fault)
    );

    // A simultaneous read and write is handled as a store.
    assign wr_hit     = !reset && (state_reg == IDLE) && access_ok && write && hit;
    assign fetch_done = (state_reg == FETCH) && !mem_busywait;

    assign misaligned = !reset && req && align_fault;
    assign busywait   = !reset && access_ok && ((state_reg != IDLE) || !hit);
    assign readdata   = (!reset && (state_reg == IDLE) && access_ok && !write && hit)
                        ? load_data : 32'h0;

    always_comb begin
        state_next    = state_reg;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_reg)
            IDLE: begin
                if (access_ok && !hit) begin
                    state_next = (valid_reg[index] && dirty_reg[index]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, index};
                mem_writedata = line;
                if (!mem_busywait) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {tag, index};
                if (!mem_busywait) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (wr_hit) begin
                dirty_reg[index] <= 1'b1;
            end
            if (fetch_done) begin
                valid_reg[index] <= 1'b1;
                dirty_reg[index] <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; the valid bits alone decide what is meaningful.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (wr_hit) begin
                data_mem[index] <= store_line;
            end
            if (fetch_done) begin
                data_mem[index] <= mem_readdata;
                tag_mem[index]  <= tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_param.sv
// Scoreboarded bench for dcache_wb_param against a 3-cycle block memory model.
module tb_dcache_wb_param;
    import dcache_pkg::*;

    localparam int BLK_W = 128;
    localparam int MA_W  = 28;
    localparam int LAT   = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              read;
    logic              write;
    logic [31:0]       address;
    logic [2:0]        funct3;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              busywait;
    logic              misaligned;
    logic              mem_read;
    logic              mem_write;
    logic [MA_W-1:0]   mem_address;
    logic [BLK_W-1:0]  mem_writedata;
    logic [BLK_W-1:0]  mem_readdata;
    logic              mem_busywait;

    always #5 clock = ~clock;

    dcache_wb_param dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .write        (write),
        .address      (address),
        .funct3       (funct3),
        .writedata    (writedata),
        .readdata     (readdata),
        .busywait     (busywait),
        .misaligned   (misaligned),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    // Block memory: unwritten blocks hold an address-derived pattern.
    function automatic logic [BLK_W-1:0] base_block(input logic [MA_W-1:0] a);
        logic [BLK_W-1:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = {4'hA, a[19:0], 8'(w)};
        end
        if (a == 28'h4) begin
            b[31:0] = 32'h11223344;
        end
        return b;
    endfunction

    logic [BLK_W-1:0] wr_data [16];
    logic [15:0]      wr_valid = '0;
    int               mem_cnt = 0;
    int               wb_count = 0;
    logic [MA_W-1:0]  last_rd_addr = '0;
    logic [31:0]      last_wb_word0 = '0;
    logic             mem_req;

    assign mem_req      = mem_read | mem_write;
    assign mem_busywait = mem_req && (mem_cnt != LAT - 1);
    assign mem_readdata = wr_valid[mem_address[3:0]] ? wr_data[mem_address[3:0]]
                                                      : base_block(mem_address);

    always @(posedge clock) begin
        if (mem_req && !mem_busywait) begin
            mem_cnt <= 0;
            if (mem_write) begin
                wr_data[mem_address[3:0]]  <= mem_writedata;
                wr_valid[mem_address[3:0]] <= 1'b1;
                wb_count                   <= wb_count + 1;
                last_wb_word0              <= mem_writedata[31:0];
            end else begin
                last_rd_addr <= mem_address;
            end
        end else if (mem_req) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] exp_data;
        int          exp_wait;
    } exp_t;

    exp_t sb_q[$];

    logic            snap_busy0;
    logic            snap_rd;
    logic            snap_wr;
    logic [MA_W-1:0] snap_addr;
    logic [31:0]     snap_wdata;

    // Drive one request at a negedge, wait for busywait to drop, then let the commit edge pass.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] exp_data,
                          input int exp_wait);
        exp_t e;
        int   waited;
        read      = rd;
        write     = wr;
        address   = addr;
        funct3    = f3;
        writedata = wd;
        e.tag      = tag;
        e.exp_data = exp_data;
        e.exp_wait = exp_wait;
        sb_q.push_back(e);
        snap_rd    = 1'b0;
        snap_wr    = 1'b0;
        snap_addr  = '0;
        snap_wdata = '0;
        waited     = 0;
        #1;
        snap_busy0 = busywait;
        while (busywait && waited < 50) begin
            @(negedge clock);
            waited++;
            if (waited == 1) begin
                snap_rd    = mem_read;
                snap_wr    = mem_write;
                snap_addr  = mem_address;
                snap_wdata = mem_writedata[31:0];
            end
            #1;
        end
        e = sb_q.pop_front();
        check_eq({e.tag, "_busy"}, 32'(busywait), 32'h0);
        check_eq({e.tag, "_wait"}, 32'(waited), 32'(e.exp_wait));
        if (rd && !wr) begin
            check_eq({e.tag, "_data"}, readdata, e.exp_data);
        end
        $display("txn %s rd=%0b wr=%0b addr=0x%08h f3=%0d wd=0x%08h rdata=0x%08h waited=%0d",
                 tag, rd, wr, addr, f3, wd, readdata, waited);
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic misaligned_probe(input string tag, input logic wr, input logic [31:0] addr,
                                    input logic [2:0] f3, input logic [31:0] wd);
        int wb_before;
        wb_before = wb_count;
        read      = !wr;
        write     = wr;
        address   = addr;
        funct3    = f3;
        writedata = wd;
        #1;
        check_eq({tag, "_mis"}, 32'(misaligned), 32'h1);
        check_eq({tag, "_busy"}, 32'(busywait), 32'h0);
        @(negedge clock);
        check_eq({tag, "_memreq"}, 32'({mem_read, mem_write}), 32'h0);
        check_eq({tag, "_wbcnt"}, 32'(wb_count), 32'(wb_before));
        $display("txn %s misaligned probe addr=0x%08h f3=%0d mis=%0b busy=%0b",
                 tag, addr, f3, misaligned, busywait);
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int wb_before;
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        funct3    = F3_W;
        writedata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busywait), 32'h0);
        check_eq("rst_mem_read", 32'(mem_read), 32'h0);
        check_eq("rst_mem_write", 32'(mem_write), 32'h0);
        check_eq("rst_mis", 32'(misaligned), 32'h0);
        check_eq("rst_rdata", readdata, 32'h0);
        check_eq("rst_mem_addr", 32'(mem_address), 32'h0);
        check_eq("rst_mem_wdata", 32'(|mem_writedata), 32'h0);
        @(negedge clock);

        // Cold clean miss
        access("cold_lw", 1'b1, 1'b0, 32'h40, F3_W, 32'h0, 32'h11223344, LAT + 1);
        check_eq("cold_busy0", 32'(snap_busy0), 32'h1);
        check_eq("cold_mem_read", 32'(snap_rd), 32'h1);
        check_eq("cold_mem_addr", 32'(snap_addr), 32'h4);
        check_eq("cold_no_wb", 32'(wb_count), 32'h0);

        // Hits: store then narrow loads
        access("sw_hit", 1'b0, 1'b1, 32'h40, F3_W, 32'hDEADBEEF, 32'h0, 0);
        access("lb_43", 1'b1, 1'b0, 32'h43, F3_B, 32'h0, 32'hFFFFFFDE, 0);
        access("lbu_43", 1'b1, 1'b0, 32'h43, F3_BU, 32'h0, 32'h000000DE, 0);
        access("lh_42", 1'b1, 1'b0, 32'h42, F3_H, 32'h0, 32'hFFFFDEAD, 0);
        access("lhu_40", 1'b1, 1'b0, 32'h40, F3_HU, 32'h0, 32'h0000BEEF, 0);
        access("sb_41", 1'b0, 1'b1, 32'h41, F3_B, 32'h000000AB, 32'h0, 0);
        access("lw_40", 1'b1, 1'b0, 32'h40, F3_W, 32'h0, 32'hDEADABEF, 0);

        // Dirty conflict on index 4
        wb_before = wb_count;
        access("conflict_lw", 1'b1, 1'b0, 32'hC0, F3_W, 32'h0, 32'hA0000C00, 2 * LAT + 1);
        check_eq("conflict_mem_write", 32'(snap_wr), 32'h1);
        check_eq("conflict_wb_addr", 32'(snap_addr), 32'h4);
        check_eq("conflict_wb_data", snap_wdata, 32'hDEADABEF);
        check_eq("conflict_wb_cnt", 32'(wb_count - wb_before), 32'h1);
        check_eq("conflict_mem_word0", last_wb_word0, 32'hDEADABEF);
        check_eq("conflict_rd_addr", 32'(last_rd_addr), 32'hC);

        // Misaligned accesses leave everything untouched
        misaligned_probe("mis_lw_42", 1'b0, 32'h42, F3_W, 32'h0);
        misaligned_probe("mis_sh_41", 1'b1, 32'h41, F3_H, 32'h00001234);
        misaligned_probe("mis_sh_c1", 1'b1, 32'hC1, F3_H, 32'h00005555);
        access("lw_c0_after_mis", 1'b1, 1'b0, 32'hC0, F3_W, 32'h0, 32'hA0000C00, 0);

        // Reset in the second FETCH cycle abandons the miss
        read    = 1'b1;
        address = 32'h40;
        funct3  = F3_W;
        @(negedge clock);
        check_eq("rstmid_fetch_started", 32'(mem_read), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        read  = 1'b0;
        @(negedge clock);
        #1;
        check_eq("rstmid_mem_read", 32'(mem_read), 32'h0);
        check_eq("rstmid_mem_write", 32'(mem_write), 32'h0);
        check_eq("rstmid_busy", 32'(busywait), 32'h0);
        $display("txn rstmid reset during fetch mem_read=%0b busy=%0b", mem_read, busywait);
        reset = 1'b0;
        @(negedge clock);
        access("reload_lw_40", 1'b1, 1'b0, 32'h40, F3_W, 32'h0, 32'hDEADABEF, LAT + 1);
        check_eq("reload_mem_read", 32'(snap_rd), 32'h1);
        check_eq("reload_rd_addr", 32'(last_rd_addr), 32'h4);

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dcache_wb_param.md
Name: dcache_wb_param

Overview:
- Parametrised, direct-mapped, write-back, write-allocate data cache for the RISC-V pipeline MEM stage.
- Sits between the MEM stage and block-wide data memory.
- Supports RV32 load and store widths (byte, half, word, with sign or zero extension) selected by funct3.
- Generalises set count and block size over the fixed 8-set, 4-word design.

Parameters:
- ADDR_W, 32, byte address width.
- SETS, 8, number of lines; power of two, at least 2.
- WORDS_PER_BLOCK, 4, 32-bit words per line; power of two, at least 1.
- Derived: OFF_W = 2 + log2(WORDS_PER_BLOCK); IDX_W = log2(SETS); TAG_W = ADDR_W - OFF_W - IDX_W; BLK_W = 32 * WORDS_PER_BLOCK.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- read, in, 1, load request; held until busywait is low.
- write, in, 1, store request; held until busywait is low.
- address, in, ADDR_W, byte address.
- funct3, in, 3, access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- writedata, in, 32, store data; low bits are used for SB/SH.
- readdata, out, 32, extended load data.
- busywait, out, 1, stall for the pipeline.
- misaligned, out, 1, alignment fault flag.
- mem_read, out, 1, block fetch request.
- mem_write, out, 1, block write-back request.
- mem_address, out, ADDR_W-OFF_W, block address.
- mem_writedata, out, BLK_W, victim block.
- mem_readdata, in, BLK_W, fetched block.
- mem_busywait, in, 1, memory busy.

Behaviour:
- Reset:
  - All valid and dirty bits cleared; state returns to IDLE.
  - busywait, mem_read, mem_write and misaligned are 0; readdata is 0.
  - mem_address and mem_writedata are 0.
- Address split: offset = address[OFF_W-1:0], index = next IDX_W bits, tag = top TAG_W bits.
- Hit: valid[index] is set and tag[index] equals tag.
- Request: read or write is high. If both are high, the access is treated as a write.
- Misaligned access: halfword at an odd address, or word at address[1:0] != 0.
  - misaligned=1 combinationally; busywait=0.
  - No array or memory side effect.
- Read hit (IDLE):
  - Zero-wait: busywait=0.
  - readdata is driven combinationally from the selected word and byte lanes, sign- or zero-extended per funct3.
- Write hit (IDLE):
  - busywait=0.
  - At the clock edge, only the addressed byte lanes are merged (SB one lane, SH two, SW four) and dirty is set.
- Miss (IDLE):
  - busywait=1 combinationally.
  - At the clock edge, go to WRITEBACK if the victim is valid and dirty, otherwise to FETCH.
- Memory handshake, common to WRITEBACK and FETCH:
  - The request is held stable from state entry.
  - The transaction completes at the first edge that is at least 1 cycle after entry and has mem_busywait=0.
- WRITEBACK:
  - mem_write=1; mem_address = {victim tag, index}; mem_writedata = line.
  - On completion go to FETCH.
- FETCH:
  - mem_read=1; mem_address = {tag, index}.
  - On completion write mem_readdata to the line, set valid=1, dirty=0, store the tag, and go to IDLE.
- After FETCH the request is re-evaluated in IDLE and hits.
  - Clean-miss latency: memory cycles + 1.
  - Dirty-miss latency: write-back cycles + fetch cycles + 1.
- busywait = request and not misaligned and (state != IDLE or not hit).
- Address, funct3 and writedata may change only while busywait=0. Changes during a miss are undefined.
- Reset mid-miss: the next edge forces IDLE with mem_read=mem_write=0. The abandoned memory transaction is ignored, and the line is not updated.
- Requests with read and write both low: no side effect; busywait=0.

Decomposition:
- Package dcache_pkg:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum: IDLE, WRITEBACK, FETCH.
  - Derived-width helper functions.
- Sub-module dcache_align (combinational):
  - Load path: word and lane select plus sign/zero extension.
  - Store path: byte-enable generation and merge into the 32-bit word.
  - misaligned detection.
- The top level holds the arrays, the FSM and the memory interface.

Test Plan (SETS=8, WORDS_PER_BLOCK=4; memory model has 3-cycle latency):
- Cold load: reset, then LW 0x00000040 → busywait=1, mem_read=1, mem_address=0x0000004. Memory returns a block with word0=0x11223344. Then busywait=0, readdata=0x11223344, mem_write never asserted.
- Store and loads on a hit: SW 0x40 0xDEADBEEF (busywait stays 0), then:
  - LB 0x43 → 0xFFFFFFDE
  - LBU 0x43 → 0x000000DE
  - LH 0x42 → 0xFFFFDEAD
  - LHU 0x40 → 0x0000BEEF
- Partial store: SB 0x41 writedata 0x000000AB, then LW 0x40 → 0xDEADABEF.
- Dirty conflict: after the above, LW 0x000000C0 (same index 4).
  - mem_write with mem_address=0x0000004 and mem_writedata[31:0]=0xDEADABEF.
  - Then mem_read with mem_address=0x000000C.
  - Then readdata = the fetched word0.
- Misaligned: LW 0x42 → misaligned=1, busywait=0, no mem_read/mem_write. SH 0x41 → same, and line contents unchanged.
- Reset during FETCH (second cycle) → next edge mem_read=0, busywait=0. A repeated LW 0x40 misses again.
